// File: rtl/core_if_id_pkg.sv
// Shared constants for the IF/ID pipeline register: NOP encoding,
// pipeline hold levels and FSM state encodings.
package core_if_id_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Hold levels driven by core_ctrl
    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_PC   = 3'b001;
    localparam logic [2:0] HOLD_IF   = 3'b010;
    localparam logic [2:0] HOLD_ID   = 3'b011;

    // IF/ID FSM state encodings
    localparam logic IF_ID_RUN    = 1'b0;
    localparam logic IF_ID_SQUASH = 1'b1;

    // True when the hold level freezes this stage (HoldIf and above)
    function automatic logic holds_if_id(input logic [2:0] hold);
        return hold >= HOLD_IF;
    endfunction

endpackage

// File: rtl/core_evt_cnt.sv
// Free-running event counter: wraps modulo 2^W, synchronous reset, enable.
module core_evt_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled events, wrapping naturally at the top
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= count + W'(1);
    end

endmodule

// File: rtl/core_if_id.sv
// IF/ID pipeline register. Registers the fetched instruction and address,
// honours hold/jump from core_ctrl, and after each jump squashes a fixed
// number of loads to hide the synchronous ROM's extra cycle of latency.
module core_if_id
    import core_if_id_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR    = 32'h0000_0000,
    parameter int          SQUASH_CYCLES = 1,
    parameter int          CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_in,
    input  logic [31:0]      inst_addr_in,
    input  logic [2:0]       hold_flag_in,
    input  logic             jump_flag_in,
    output logic [31:0]      inst_out,
    output logic [31:0]      inst_addr_out,
    output logic             inst_valid_out,
    output logic             squash_busy_out,
    output logic [CNT_W-1:0] stall_cnt_out,
    output logic [CNT_W-1:0] flush_cnt_out
);

    localparam logic [2:0] SQ_LOAD   = 3'(SQUASH_CYCLES);
    localparam logic       SQ_ENABLE = (SQUASH_CYCLES != 0);

    logic       state;
    logic [2:0] sq_cnt;
    logic       hold;

    assign hold = holds_if_id(hold_flag_in);

    // Data/valid registers and squash FSM; priority rst > jump > hold > load
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_out       <= INST_NOP;
            inst_addr_out  <= RESET_ADDR;
            inst_valid_out <= 1'b0;
            state          <= IF_ID_RUN;
            sq_cnt         <= 3'd0;
        end else if (jump_flag_in) begin
            // Address is left alone: the bubble keeps the last known PC
            inst_out       <= INST_NOP;
            inst_valid_out <= 1'b0;
            if (SQ_ENABLE) begin
                state  <= IF_ID_SQUASH;
                sq_cnt <= SQ_LOAD;
            end
        end else if (!hold) begin
            inst_addr_out <= inst_addr_in;
            if (state == IF_ID_SQUASH) begin
                inst_out       <= INST_NOP;
                inst_valid_out <= 1'b0;
                sq_cnt         <= sq_cnt - 3'd1;
                if (sq_cnt == 3'd1)
                    state <= IF_ID_RUN;
            end else if (hold_flag_in == HOLD_PC) begin
                // Fetch already sends a NOP here; mark it as a bubble
                inst_out       <= INST_NOP;
                inst_valid_out <= 1'b0;
            end else begin
                inst_out       <= inst_in;
                inst_valid_out <= 1'b1;
            end
        end
    end

    assign squash_busy_out = (state == IF_ID_SQUASH);

    // A jump that coincides with a hold is a flush, not a stall
    core_evt_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (hold && !jump_flag_in),
        .count (stall_cnt_out)
    );

    core_evt_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (jump_flag_in),
        .count (flush_cnt_out)
    );

endmodule

// File: tb/tb_core_if_id.sv
// Self-checking bench for core_if_id: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_core_if_id;

    localparam logic [31:0] RADDR = 32'h100;
    localparam int          SQ    = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_in = '0;
    logic [31:0] inst_addr_in = '0;
    logic [2:0]  hold_flag_in = '0;
    logic        jump_flag_in = 1'b0;
    logic [31:0] inst_out, inst_addr_out;
    logic        inst_valid_out, squash_busy_out;
    logic [31:0] stall_cnt_out, flush_cnt_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_inst, m_addr;
    logic        m_valid;
    int          m_left;      // squashed loads still owed after a jump
    logic [31:0] m_stall, m_flush;

    core_if_id #(.RESET_ADDR(RADDR), .SQUASH_CYCLES(SQ), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_in         (inst_in),
        .inst_addr_in    (inst_addr_in),
        .hold_flag_in    (hold_flag_in),
        .jump_flag_in    (jump_flag_in),
        .inst_out        (inst_out),
        .inst_addr_out   (inst_addr_out),
        .inst_valid_out  (inst_valid_out),
        .squash_busy_out (squash_busy_out),
        .stall_cnt_out   (stall_cnt_out),
        .flush_cnt_out   (flush_cnt_out)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model at the edge, settle
    task automatic drive(input logic r, input logic [31:0] i, input logic [31:0] a,
                         input logic [2:0] h, input logic j);
        rst = r; inst_in = i; inst_addr_in = a; hold_flag_in = h; jump_flag_in = j;
        @(posedge clk);
        if (r) begin
            m_inst = NOP; m_addr = RADDR; m_valid = 0; m_left = 0; m_stall = 0; m_flush = 0;
        end else if (j) begin
            m_inst = NOP; m_valid = 0; m_flush++; m_left = SQ;
        end else if (h >= 3'd2) begin
            m_stall++;
        end else begin
            m_addr = a;
            if (m_left > 0) begin
                m_inst = NOP; m_valid = 0; m_left--;
            end else if (h == 3'd1) begin
                m_inst = NOP; m_valid = 0;
            end else begin
                m_inst = i; m_valid = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 32'h1234_5678, 32'h40, 0, 0);
        drive(1, 32'h1234_5678, 32'h40, 0, 1);
        checks++; if (inst_out !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", inst_out, NOP); end
        checks++; if (inst_addr_out !== 32'h100) begin errors++; $display("FAIL reset_addr got %h exp %h", inst_addr_out, 32'h100); end
        checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid_out); end
        checks++; if (squash_busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", squash_busy_out); end
        checks++; if (stall_cnt_out !== 0 || flush_cnt_out !== 0) begin errors++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", stall_cnt_out, flush_cnt_out); end
    endtask

    task automatic test_stream();
        drive(0, 32'h0050_0093, 32'h0, 0, 0);
        checks++; if (inst_out !== 32'h0050_0093 || inst_addr_out !== 32'h0 || inst_valid_out !== 1'b1) begin
            errors++; $display("FAIL stream0 got %h@%h v%b exp 00500093@00000000 v1", inst_out, inst_addr_out, inst_valid_out); end
        drive(0, 32'h0020_8133, 32'h4, 0, 0);
        checks++; if (inst_out !== 32'h0020_8133 || inst_addr_out !== 32'h4 || inst_valid_out !== 1'b1) begin
            errors++; $display("FAIL stream1 got %h@%h v%b exp 00208133@00000004 v1", inst_out, inst_addr_out, inst_valid_out); end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 3; k++) begin
            drive(0, $urandom, 32'h8 + 32'(4 * k), 3'b010, 0);
            checks++; if (inst_out !== 32'h0020_8133 || inst_addr_out !== 32'h4 || inst_valid_out !== 1'b1) begin
                errors++; $display("FAIL hold_frozen got %h@%h v%b exp 00208133@00000004 v1", inst_out, inst_addr_out, inst_valid_out); end
        end
        checks++; if (stall_cnt_out !== 32'd3) begin errors++; $display("FAIL hold_stall got %0d exp 3", stall_cnt_out); end
        drive(0, NOP, 32'h8, 3'b001, 0);
        checks++; if (inst_out !== NOP || inst_addr_out !== 32'h8 || inst_valid_out !== 1'b0) begin
            errors++; $display("FAIL hold_pc got %h@%h v%b exp 00000013@00000008 v0", inst_out, inst_addr_out, inst_valid_out); end
    endtask

    task automatic test_jump_squash();
        drive(0, 32'h1111_1111, 32'h20, 0, 1);
        checks++; if (inst_valid_out !== 1'b0 || squash_busy_out !== 1'b1 || inst_addr_out !== 32'h8) begin
            errors++; $display("FAIL jump got v%b busy%b addr %h exp v0 busy1 addr 00000008", inst_valid_out, squash_busy_out, inst_addr_out); end
        drive(0, 32'hDEAD_BEEF, 32'h24, 0, 0);
        checks++; if (inst_out !== NOP || inst_valid_out !== 1'b0 || squash_busy_out !== 1'b1) begin
            errors++; $display("FAIL squash1 got %h v%b busy%b exp 00000013 v0 busy1", inst_out, inst_valid_out, squash_busy_out); end
        drive(0, 32'hDEAD_BEEF, 32'h28, 0, 0);
        checks++; if (inst_out !== NOP || inst_valid_out !== 1'b0 || squash_busy_out !== 1'b0 || inst_addr_out !== 32'h28) begin
            errors++; $display("FAIL squash2 got %h@%h v%b busy%b exp 00000013@00000028 v0 busy0", inst_out, inst_addr_out, inst_valid_out, squash_busy_out); end
        drive(0, 32'hDEAD_BEEF, 32'h2c, 0, 0);
        checks++; if (inst_out !== 32'hDEAD_BEEF || inst_valid_out !== 1'b1) begin
            errors++; $display("FAIL post_squash got %h v%b exp deadbeef v1", inst_out, inst_valid_out); end
        checks++; if (flush_cnt_out !== 32'd1) begin errors++; $display("FAIL flush_cnt got %0d exp 1", flush_cnt_out); end
    endtask

    task automatic test_jump_over_hold();
        logic [31:0] s0, f0;
        s0 = stall_cnt_out; f0 = flush_cnt_out;
        drive(0, 32'h2222_2222, 32'h30, 3'b011, 1);
        checks++; if (inst_out !== NOP || inst_valid_out !== 1'b0) begin
            errors++; $display("FAIL jmp_hold_out got %h v%b exp 00000013 v0", inst_out, inst_valid_out); end
        checks++; if (flush_cnt_out !== f0 + 1 || stall_cnt_out !== s0) begin
            errors++; $display("FAIL jmp_hold_cnt got %0d/%0d exp %0d/%0d", flush_cnt_out, stall_cnt_out, f0 + 1, s0); end
        drive(0, 32'h3, 32'h34, 0, 0);
        drive(0, 32'h4, 32'h38, 0, 0);
    endtask

    task automatic test_reload_and_reset();
        drive(0, 32'h5, 32'h40, 0, 1);
        drive(0, 32'h6, 32'h44, 0, 0);                 // counter now 1
        drive(0, 32'h7, 32'h48, 0, 1);                 // reload to 2
        for (int k = 0; k < 2; k++) begin
            drive(0, 32'h8, 32'h4c, 3'b010, 0);
            checks++; if (squash_busy_out !== 1'b1 || inst_valid_out !== 1'b0 || inst_addr_out !== 32'h44) begin
                errors++; $display("FAIL reload_hold got busy%b v%b addr %h exp busy1 v0 addr 00000044", squash_busy_out, inst_valid_out, inst_addr_out); end
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 32'hA0 + 32'(k), 32'h50 + 32'(4 * k), 0, 0);
            checks++; if (inst_valid_out !== 1'b0 || inst_out !== NOP) begin
                errors++; $display("FAIL reload_squash%0d got %h v%b exp 00000013 v0", k, inst_out, inst_valid_out); end
        end
        drive(0, 32'hB0, 32'h58, 0, 0);
        checks++; if (inst_valid_out !== 1'b1 || inst_out !== 32'hB0) begin
            errors++; $display("FAIL reload_done got %h v%b exp 000000b0 v1", inst_out, inst_valid_out); end
        drive(0, 32'hC0, 32'h60, 0, 1);
        drive(1, 32'hC1, 32'h64, 0, 0);
        checks++; if (squash_busy_out !== 1'b0 || inst_addr_out !== RADDR) begin
            errors++; $display("FAIL mid_rst got busy%b addr %h exp busy0 addr 00000100", squash_busy_out, inst_addr_out); end
        drive(0, 32'hC2, 32'h68, 0, 0);
        checks++; if (inst_valid_out !== 1'b1 || inst_out !== 32'hC2) begin
            errors++; $display("FAIL after_rst got %h v%b exp 000000c2 v1", inst_out, inst_valid_out); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic r, j;
            logic [2:0] h;
            r = ($urandom_range(0, 49) == 0);
            j = ($urandom_range(0, 6) == 0);
            h = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 3)) : 3'd0;
            drive(r, $urandom, $urandom, h, j);
            checks++;
            if (inst_out !== m_inst || inst_addr_out !== m_addr || inst_valid_out !== m_valid ||
                squash_busy_out !== (m_left > 0) || stall_cnt_out !== m_stall || flush_cnt_out !== m_flush) begin
                errors++;
                $display("FAIL rand%0d got %h@%h v%b b%b s%0d f%0d exp %h@%h v%b b%b s%0d f%0d", n,
                         inst_out, inst_addr_out, inst_valid_out, squash_busy_out, stall_cnt_out, flush_cnt_out,
                         m_inst, m_addr, m_valid, (m_left > 0), m_stall, m_flush);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_jump_squash();
        test_jump_over_hold();
        test_reload_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
